// File: rtl/exec_result_tracker.sv
// ---------------------------------------------------------------------------
// exec_result_tracker
//
// Purpose:
//   In-order result tracker for the execute stage. Each issued op takes one of
//   DEPTH tagged slots, kept in a circular FIFO where head is the oldest op.
//   Ops can complete out of order: an op may be done at issue (ALU, jal link),
//   or it completes later through the tagged result port (FPU, mem, UART).
//   Writeback to the register file always happens in order, at most one op
//   per cycle. Two combinational lookups forward in-flight results, or signal
//   a stall when the producer has not finished yet. A flush squashes every
//   in-flight op and toggles the epoch bit. Late results that still carry the
//   old epoch are then ignored.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   issue_valid_i/issue_ready_o   issue handshake (ready = ~full & ~flush)
//   issue_wen_i/issue_fmode_i/issue_rd_i   destination of the op
//   issue_done_i/issue_data_i     result already known at issue
//   issue_tag_o                   {epoch, tail} of the slot being allocated
//   res_valid_i/res_tag_i/res_data_i       long-latency completion
//   flush_i                       squash all in-flight ops
//   srcN_fmode_i/srcN_no_i        lookup keys (N = 1, 2)
//   srcN_hit_o/srcN_stall_o/srcN_data_o    forwarding results
//   wb_valid_o/wb_wen_o/wb_fmode_o/wb_reg_o/wb_data_o  registered writeback
// ---------------------------------------------------------------------------
module exec_result_tracker #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    parameter  int REG_W = 5,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic             issue_wen_i,
    input  logic             issue_fmode_i,
    input  logic [REG_W-1:0] issue_rd_i,
    input  logic             issue_done_i,
    input  logic [XLEN-1:0]  issue_data_i,
    output logic [TAG_W-1:0] issue_tag_o,
    input  logic             res_valid_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic [XLEN-1:0]  res_data_i,
    input  logic             flush_i,
    input  logic             src1_fmode_i,
    input  logic [REG_W-1:0] src1_no_i,
    input  logic             src2_fmode_i,
    input  logic [REG_W-1:0] src2_no_i,
    output logic             src1_hit_o,
    output logic             src1_stall_o,
    output logic [XLEN-1:0]  src1_data_o,
    output logic             src2_hit_o,
    output logic             src2_stall_o,
    output logic [XLEN-1:0]  src2_data_o,
    output logic             wb_valid_o,
    output logic             wb_wen_o,
    output logic             wb_fmode_o,
    output logic [REG_W-1:0] wb_reg_o,
    output logic [XLEN-1:0]  wb_data_o
);

    localparam int CNT_W = IDX_W + 1;

    // Slot storage
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q,  done_d;
    logic [DEPTH-1:0] wen_q,   wen_d;
    logic [DEPTH-1:0] fmode_q, fmode_d;
    logic [REG_W-1:0] rd_q   [DEPTH];
    logic [REG_W-1:0] rd_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    // FIFO pointers and epoch
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             epoch_q, epoch_d;

    // Registered writeback port
    logic             wb_valid_q, wb_valid_d;
    logic             wb_wen_q,   wb_wen_d;
    logic             wb_fmode_q, wb_fmode_d;
    logic [REG_W-1:0] wb_reg_q,   wb_reg_d;
    logic [XLEN-1:0]  wb_data_q,  wb_data_d;

    logic             full;
    logic             issue_fire;
    logic             wb_fire;
    logic [DEPTH-1:0] slot_res_hit;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    // A full tracker refuses issue even when the head pops on the same edge,
    // so a slot is never freed and reused in one cycle.
    assign full          = (count_q == CNT_W'(DEPTH));
    assign issue_ready_o = ~full & ~flush_i;
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign issue_tag_o   = {epoch_q, tail_q};
    assign wb_fire       = valid_q[head_q] & done_q[head_q] & ~flush_i;

    // Per-slot completion and lookup matching. A completion only lands on a
    // valid, still-pending slot of the current epoch. Integer r0 never matches
    // because it is hard-wired to zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_res_hit[gi] = res_valid_i
                                & (res_tag_i == {epoch_q, IDX_W'(gi)})
                                & valid_q[gi] & ~done_q[gi];
        assign match1[gi] = valid_q[gi] & wen_q[gi]
                          & (fmode_q[gi] == src1_fmode_i)
                          & (rd_q[gi] == src1_no_i)
                          & ~(~fmode_q[gi] & (rd_q[gi] == '0));
        assign match2[gi] = valid_q[gi] & wen_q[gi]
                          & (fmode_q[gi] == src2_fmode_i)
                          & (rd_q[gi] == src2_no_i)
                          & ~(~fmode_q[gi] & (rd_q[gi] == '0));
    end

    // Forwarding. The scan walks from head (oldest) towards tail, so the last
    // match seen is the youngest producer of the register. A result arriving
    // this cycle for that producer is bypassed straight through.
    always_comb begin
        logic             found1, found2;
        logic [IDX_W-1:0] sel1, sel2;
        logic [IDX_W-1:0] idx;
        found1 = 1'b0;
        found2 = 1'b0;
        sel1   = '0;
        sel2   = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + IDX_W'(k);
            if (match1[idx]) begin
                found1 = 1'b1;
                sel1   = idx;
            end
            if (match2[idx]) begin
                found2 = 1'b1;
                sel2   = idx;
            end
        end

        src1_hit_o   = found1;
        src1_stall_o = 1'b0;
        src1_data_o  = '0;
        if (found1) begin
            if (done_q[sel1]) begin
                src1_data_o = data_q[sel1];
            end else if (slot_res_hit[sel1]) begin
                src1_data_o = res_data_i;
            end else begin
                src1_stall_o = 1'b1;
                src1_data_o  = data_q[sel1];
            end
        end

        src2_hit_o   = found2;
        src2_stall_o = 1'b0;
        src2_data_o  = '0;
        if (found2) begin
            if (done_q[sel2]) begin
                src2_data_o = data_q[sel2];
            end else if (slot_res_hit[sel2]) begin
                src2_data_o = res_data_i;
            end else begin
                src2_stall_o = 1'b1;
                src2_data_o  = data_q[sel2];
            end
        end
    end

    // Next-state logic
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        wen_d   = wen_q;
        fmode_d = fmode_q;
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]   = rd_q[i];
            data_d[i] = data_q[i];
        end
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        epoch_d    = epoch_q;
        wb_valid_d = 1'b0;
        wb_wen_d   = wb_wen_q;
        wb_fmode_d = wb_fmode_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;

        if (flush_i) begin
            // Same-edge issue, completion and head writeback are all dropped.
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            epoch_d = ~epoch_q;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_res_hit[i]) begin
                    done_d[i] = 1'b1;
                    data_d[i] = res_data_i;
                end
            end

            if (wb_fire) begin
                wb_valid_d      = 1'b1;
                wb_wen_d        = wen_q[head_q];
                wb_fmode_d      = fmode_q[head_q];
                wb_reg_d        = rd_q[head_q];
                wb_data_d       = data_q[head_q];
                valid_d[head_q] = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end

            // Issue never lands on the popping slot: a pop needs count>0 and
            // issue needs count<DEPTH, so tail differs from head then.
            if (issue_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = issue_done_i;
                wen_d[tail_q]   = issue_wen_i;
                fmode_d[tail_q] = issue_fmode_i;
                rd_d[tail_q]    = issue_rd_i;
                data_d[tail_q]  = issue_done_i ? issue_data_i : '0;
                tail_d          = tail_q + IDX_W'(1);
            end

            case ({issue_fire, wb_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            done_q  <= '0;
            wen_q   <= '0;
            fmode_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            epoch_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_fmode_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            fmode_q <= fmode_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            epoch_q    <= epoch_d;
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_fmode_q <= wb_fmode_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_wen_o   = wb_wen_q;
    assign wb_fmode_o = wb_fmode_q;
    assign wb_reg_o   = wb_reg_q;
    assign wb_data_o  = wb_data_q;

endmodule
